// File: rtl/sprite_compositor_if.sv
// Signal bundle for sprite_compositor: pixel stream in/out, sprite attribute writes,
// frightened-mode control and the per-sprite bitmap ROM port.
interface sprite_compositor_if #(
   parameter int NUM_SPRITES = 4,
   parameter int COORD_W     = 10
);
   localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

   logic                     frame_start;
   logic                     pixel_valid;
   logic [COORD_W-1:0]       DrawX;
   logic [COORD_W-1:0]       DrawY;
   logic [23:0]              bg_rgb;
   logic                     wr_en;
   logic [IDX_W-1:0]         wr_idx;
   logic [COORD_W-1:0]       wr_x;
   logic [COORD_W-1:0]       wr_y;
   logic [23:0]              wr_color;
   logic                     wr_enable;
   logic [1:0]               wr_flip;
   logic [NUM_SPRITES-1:0]   ghost_mask;
   logic                     fright_start;
   logic [NUM_SPRITES*3-1:0] row_addr;
   logic [NUM_SPRITES*8-1:0] row_data;
   logic                     fright_active;
   logic [7:0]               Red;
   logic [7:0]               Green;
   logic [7:0]               Blue;
   logic                     out_valid;

   modport master (
      output frame_start, pixel_valid, DrawX, DrawY, bg_rgb,
             wr_en, wr_idx, wr_x, wr_y, wr_color, wr_enable, wr_flip,
             ghost_mask, fright_start, row_data,
      input  row_addr, fright_active, Red, Green, Blue, out_valid
   );

   modport slave (
      input  frame_start, pixel_valid, DrawX, DrawY, bg_rgb,
             wr_en, wr_idx, wr_x, wr_y, wr_color, wr_enable, wr_flip,
             ghost_mask, fright_start, row_data,
      output row_addr, fright_active, Red, Green, Blue, out_valid
   );
endinterface

// File: rtl/sprite_compositor.sv
// Pipelined sprite overlay: double-buffered attributes, priority compositing and frightened-ghost
// recolouring. Defining SPRITE_MIRROR_EN adds per-sprite hflip/vflip storage and mapping.
module sprite_compositor #(
   parameter int NUM_SPRITES   = 4,
   parameter int COORD_W       = 10,
   parameter int FRIGHT_FRAMES = 360,
   parameter int BLINK_FRAMES  = 120
) (
   input  logic               Clk,
   input  logic               Reset,
   sprite_compositor_if.slave bus
);
   localparam int CNT_W = $clog2(FRIGHT_FRAMES + 1);
   localparam int HI_W  = COORD_W - 2;

   typedef struct packed {
      logic               en;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [23:0]        color;
`ifdef SPRITE_MIRROR_EN
      logic [1:0]         flip;
`endif
   } attr_t;

   localparam attr_t ATTR_ZERO = {$bits(attr_t){1'b0}};

   attr_t                  shadow_r     [NUM_SPRITES];
   attr_t                  active_r     [NUM_SPRITES];
   attr_t                  shadow_nxt_s [NUM_SPRITES];
   logic [COORD_W:0]       dx_s         [NUM_SPRITES];
   logic [COORD_W:0]       dy_s         [NUM_SPRITES];
   logic [NUM_SPRITES-1:0] hit_s;

   logic                   s1_valid_r;
   logic [23:0]            s1_bg_r;
   logic [NUM_SPRITES-1:0] s1_hit_r;
   logic [2:0]             s1_dx_r [NUM_SPRITES];
`ifdef SPRITE_MIRROR_EN
   logic [NUM_SPRITES-1:0] s1_hflip_r;
`endif

   logic [NUM_SPRITES-1:0] pix_s;
   logic [2:0]             col_s;
   logic [7:0]             row_byte_s;
   logic [23:0]            win_color_s;
   logic                   win_ghost_s;
   logic [23:0]            comp_color_s;

   logic [CNT_W-1:0]       fright_cnt_r;
   logic [CNT_W-1:0]       fright_nxt_s;
   logic                   fright_active_r;
   logic [23:0]            out_rgb_r;
   logic                   out_valid_r;

   // Shadow bank with this cycle's write folded in; this is also what a frame start commits.
   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         shadow_nxt_s[i] = shadow_r[i];
         if (bus.wr_en && (32'(bus.wr_idx) == 32'(i))) begin
            shadow_nxt_s[i].en    = bus.wr_enable;
            shadow_nxt_s[i].x     = bus.wr_x;
            shadow_nxt_s[i].y     = bus.wr_y;
            shadow_nxt_s[i].color = bus.wr_color;
`ifdef SPRITE_MIRROR_EN
            shadow_nxt_s[i].flip  = bus.wr_flip;
`endif
         end else begin
            shadow_nxt_s[i] = shadow_r[i];
         end
      end
   end

   // Shadow and active attribute banks.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow_r[i] <= ATTR_ZERO;
            active_r[i] <= ATTR_ZERO;
         end
      end else begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            shadow_r[i] <= shadow_nxt_s[i];
            if (bus.frame_start) begin
               active_r[i] <= shadow_nxt_s[i];
            end
         end
      end
   end

   // Stage 0: sprite-relative offsets, hit test and ROM row addressing.
   always_comb begin
      hit_s        = {NUM_SPRITES{1'b0}};
      bus.row_addr = {(NUM_SPRITES*3){1'b0}};
      for (int i = 0; i < NUM_SPRITES; i++) begin
         dx_s[i] = {1'b0, bus.DrawX} - {1'b0, active_r[i].x};
         dy_s[i] = {1'b0, bus.DrawY} - {1'b0, active_r[i].y};
         // A borrow sets the top bit, so DrawX < x never aliases into the 0..7 window.
         hit_s[i] = active_r[i].en && (dx_s[i][COORD_W:3] == {HI_W{1'b0}})
                                   && (dy_s[i][COORD_W:3] == {HI_W{1'b0}});
`ifdef SPRITE_MIRROR_EN
         bus.row_addr[3*i +: 3] = active_r[i].flip[1] ? ~dy_s[i][2:0] : dy_s[i][2:0];
`else
         bus.row_addr[3*i +: 3] = dy_s[i][2:0];
`endif
      end
   end

   // Stage 0 -> 1 pipeline register.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_valid_r <= 1'b0;
         s1_bg_r    <= 24'h000000;
         s1_hit_r   <= {NUM_SPRITES{1'b0}};
         for (int i = 0; i < NUM_SPRITES; i++) begin
            s1_dx_r[i] <= 3'd0;
         end
`ifdef SPRITE_MIRROR_EN
         s1_hflip_r <= {NUM_SPRITES{1'b0}};
`endif
      end else begin
         s1_valid_r <= bus.pixel_valid;
         s1_bg_r    <= bus.bg_rgb;
         s1_hit_r   <= hit_s;
         for (int i = 0; i < NUM_SPRITES; i++) begin
            s1_dx_r[i] <= dx_s[i][2:0];
`ifdef SPRITE_MIRROR_EN
            s1_hflip_r[i] <= active_r[i].flip[0];
`endif
         end
      end
   end

   // Stage 1: bitmap column select, priority pick (index 0 wins) and frightened recolour.
   always_comb begin
      pix_s        = {NUM_SPRITES{1'b0}};
      col_s        = 3'd0;
      row_byte_s   = 8'h00;
      win_color_s  = s1_bg_r;
      win_ghost_s  = 1'b0;
      comp_color_s = s1_bg_r;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
`ifdef SPRITE_MIRROR_EN
         col_s = s1_hflip_r[i] ? s1_dx_r[i] : (3'd7 - s1_dx_r[i]);
`else
         col_s = 3'd7 - s1_dx_r[i];
`endif
         row_byte_s  = bus.row_data[8*i +: 8];
         pix_s[i]    = s1_hit_r[i] & row_byte_s[col_s];
         win_color_s = pix_s[i] ? active_r[i].color : win_color_s;
         win_ghost_s = pix_s[i] ? bus.ghost_mask[i] : win_ghost_s;
      end
      if (win_ghost_s && fright_active_r) begin
         comp_color_s = ((fright_cnt_r <= CNT_W'(BLINK_FRAMES)) && fright_cnt_r[3])
                        ? 24'hFFFFFF : 24'h0000FF;
      end else begin
         comp_color_s = win_color_s;
      end
   end

   // Frightened timer next value: a (re)trigger beats the per-frame decrement.
   always_comb begin
      if (bus.fright_start) begin
         fright_nxt_s = CNT_W'(FRIGHT_FRAMES);
      end else if (bus.frame_start && (fright_cnt_r != {CNT_W{1'b0}})) begin
         fright_nxt_s = fright_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         fright_nxt_s = fright_cnt_r;
      end
   end

   // Frightened timer state.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         fright_cnt_r    <= {CNT_W{1'b0}};
         fright_active_r <= 1'b0;
      end else begin
         fright_cnt_r    <= fright_nxt_s;
         fright_active_r <= (fright_nxt_s != {CNT_W{1'b0}});
      end
   end

   // Stage 2: registered pixel output.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         out_rgb_r   <= 24'h000000;
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= s1_valid_r;
         if (s1_valid_r) begin
            out_rgb_r <= comp_color_s;
         end
      end
   end

   assign bus.Red           = out_rgb_r[23:16];
   assign bus.Green         = out_rgb_r[15:8];
   assign bus.Blue          = out_rgb_r[7:0];
   assign bus.out_valid     = out_valid_r;
   assign bus.fright_active = fright_active_r;
endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: a behavioural model predicts each pixel when it is driven,
// the monitor pops and compares when out_valid appears, and checks the 2-cycle latency.
module tb_sprite_compositor;
   localparam int NS = 4;

   logic clk   = 1'b0;
   logic Reset = 1'b1;
   always #5 clk = ~clk;

   sprite_compositor_if #(.NUM_SPRITES(NS), .COORD_W(10)) bus ();

   sprite_compositor #(
      .NUM_SPRITES(NS), .COORD_W(10), .FRIGHT_FRAMES(360), .BLINK_FRAMES(120)
   ) dut (
      .Clk(clk), .Reset(Reset), .bus(bus.slave)
   );

   typedef struct {
      bit          en;
      int          x;
      int          y;
      logic [23:0] col;
      logic [1:0]  flip;
   } mattr_t;

   mattr_t      m_sh  [NS];
   mattr_t      m_act [NS];
   int          m_cnt;
   logic [7:0]  rom [NS][8];
   logic [23:0] exp_q[$];
   int          stamp_q[$];
   int          cyc   = 0;
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous bitmap ROMs: data one cycle after the address.
   always @(posedge clk) begin
      for (int i = 0; i < NS; i++) bus.row_data[8*i +: 8] <= rom[i][bus.row_addr[3*i +: 3]];
   end

   always @(negedge clk) begin
      if (!Reset && bus.out_valid) begin
         if (exp_q.size() == 0) begin
            check_value("unexpected_out", 32'd1, 32'd0);
         end else begin
            check_value("rgb", {8'h00, bus.Red, bus.Green, bus.Blue}, {8'h00, exp_q.pop_front()});
            check_value("latency", cyc - stamp_q.pop_front(), 32'd2);
         end
      end
   end

   function automatic logic [23:0] model_pix(input int px, input int py, input logic [23:0] bg);
      logic [23:0] c = bg;
      bit ghost = 1'b0;
      for (int i = NS - 1; i >= 0; i--) begin
         int dx = px - m_act[i].x;
         int dy = py - m_act[i].y;
         if (m_act[i].en && dx >= 0 && dx < 8 && dy >= 0 && dy < 8) begin
            int row  = dy;
            int colb = 7 - dx;
`ifdef SPRITE_MIRROR_EN
            if (m_act[i].flip[1]) row = 7 - dy;
            if (m_act[i].flip[0]) colb = dx;
`endif
            if (rom[i][row][colb]) begin
               c     = m_act[i].col;
               ghost = bus.ghost_mask[i];
            end
         end
      end
      if (ghost && m_cnt != 0) c = (m_cnt <= 120 && (m_cnt & 8) != 0) ? 24'hFFFFFF : 24'h0000FF;
      return c;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_sh[i]  = '{1'b0, 0, 0, 24'h000000, 2'b00};
         m_act[i] = m_sh[i];
      end
      m_cnt = 0;
   endtask

   task automatic model_frame(input bit fr);
      if (fr) m_cnt = 360;
      else if (m_cnt > 0) m_cnt--;
      for (int i = 0; i < NS; i++) m_act[i] = m_sh[i];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_spr(input int idx, input int x, input int y, input logic [23:0] col,
                            input bit en, input logic [1:0] flip, input bit with_frame);
      bus.wr_en = 1'b1; bus.wr_idx = 2'(idx); bus.wr_x = 10'(x); bus.wr_y = 10'(y);
      bus.wr_color = col; bus.wr_enable = en; bus.wr_flip = flip;
      m_sh[idx] = '{en, x, y, col, flip};
      if (with_frame) begin
         bus.frame_start = 1'b1;
         model_frame(1'b0);
      end
      step();
      bus.wr_en = 1'b0; bus.frame_start = 1'b0;
   endtask

   task automatic frame(input bit fr);
      bus.frame_start = 1'b1; bus.fright_start = fr;
      model_frame(fr);
      step();
      bus.frame_start = 1'b0; bus.fright_start = 1'b0;
   endtask

   task automatic pixel(input int x, input int y, input logic [23:0] bg);
      bus.pixel_valid = 1'b1; bus.DrawX = 10'(x); bus.DrawY = 10'(y); bus.bg_rgb = bg;
      exp_q.push_back(model_pix(x, y, bg));
      stamp_q.push_back(cyc);
      step();
      bus.pixel_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (4) step();
   endtask

   initial begin
      bus.frame_start = 1'b0; bus.pixel_valid = 1'b0; bus.DrawX = 10'd0; bus.DrawY = 10'd0;
      bus.bg_rgb = 24'h0; bus.wr_en = 1'b0; bus.wr_idx = 2'd0; bus.wr_x = 10'd0; bus.wr_y = 10'd0;
      bus.wr_color = 24'h0; bus.wr_enable = 1'b0; bus.wr_flip = 2'b00; bus.ghost_mask = 4'b0000;
      bus.fright_start = 1'b0;
      for (int i = 0; i < NS; i++) for (int r = 0; r < 8; r++) rom[i][r] = 8'h00;
      model_reset();
      repeat (3) step();
      check_value("rst_out_valid", bus.out_valid, 32'd0);
      check_value("rst_rgb", {8'h00, bus.Red, bus.Green, bus.Blue}, 32'd0);
      check_value("rst_fright", bus.fright_active, 32'd0);
      Reset = 1'b0;
      step();

      // Shadow write is invisible until frame start.
      rom[1][0] = 8'h80;
      write_spr(1, 100, 50, 24'hFFFF00, 1'b1, 2'b00, 1'b0);
      pixel(100, 50, 24'h123456); drain();
      frame(1'b0);
      pixel(100, 50, 24'h123456); drain();

      // Priority between overlapping sprites 0 and 2.
      write_spr(0, 200, 200, 24'hAA0000, 1'b1, 2'b00, 1'b0);
      write_spr(2, 200, 200, 24'h00BB00, 1'b1, 2'b00, 1'b0);
      frame(1'b0);
      rom[0][0] = 8'h80; rom[2][0] = 8'h80;
      pixel(200, 200, 24'h010203); drain();
      rom[0][0] = 8'h00;
      pixel(200, 200, 24'h010203); drain();
      rom[2][0] = 8'h00;
      pixel(200, 200, 24'h010203); drain();
      rom[0][3] = 8'hA6; rom[2][3] = 8'h0F;
      for (int x = 196; x <= 210; x++) pixel(x, 203, 24'(x * 3));
      drain();

      // Left/right edges with no wrap-around.
      rom[3][0] = 8'hFF;
      write_spr(3, 5, 0, 24'h00FFFF, 1'b1, 2'b00, 1'b0);
      frame(1'b0);
      pixel(3, 0, 24'h445566); pixel(12, 0, 24'h445566);
      pixel(13, 0, 24'h445566); pixel(5, 0, 24'h445566);
      drain();

      // Frightened mode: full run, then a trigger coincident with frame start.
      bus.ghost_mask = 4'b1000;
      bus.fright_start = 1'b1; m_cnt = 360; step(); bus.fright_start = 1'b0;
      check_value("fright_on", bus.fright_active, 32'd1);
      for (int f = 0; f < 360; f++) begin
         frame(1'b0);
         pixel(6, 0, 24'h222222);
         check_value("fright_act", bus.fright_active, 32'(m_cnt != 0));
      end
      drain();
      frame(1'b1);
      check_value("fright_coinc", bus.fright_active, 32'd1);
      for (int f = 0; f < 241; f++) begin
         frame(1'b0);
         pixel(6, 0, 24'h333333);
      end
      drain();

      // Reset with pixels streaming.
      for (int k = 0; k < 6; k++) pixel(96 + k, 50, 24'h0A0B0C);
      Reset = 1'b1; bus.pixel_valid = 1'b1; bus.DrawX = 10'd102;
      step();
      check_value("rst_mid_valid", bus.out_valid, 32'd0);
      check_value("rst_mid_rgb", {8'h00, bus.Red, bus.Green, bus.Blue}, 32'd0);
      check_value("rst_mid_fright", bus.fright_active, 32'd0);
      Reset = 1'b0; bus.pixel_valid = 1'b0;
      exp_q.delete(); stamp_q.delete();
      model_reset();
      step();
      pixel(100, 50, 24'h0D0E0F); drain();
      write_spr(1, 100, 50, 24'hFFFF00, 1'b1, 2'b00, 1'b1);
      pixel(100, 50, 24'h0D0E0F); drain();

      // Flip mapping at the origin.
      rom[0][0] = 8'h00; rom[0][7] = 8'h01;
      write_spr(0, 0, 0, 24'h112233, 1'b1, 2'b11, 1'b1);
      bus.DrawX = 10'd0; bus.DrawY = 10'd0;
      #1;
`ifdef SPRITE_MIRROR_EN
      check_value("row_addr_flip", bus.row_addr[2:0], 32'd7);
`else
      check_value("row_addr_flip", bus.row_addr[2:0], 32'd0);
`endif
      pixel(0, 0, 24'h778899); drain();

      check_value("queue_empty", exp_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
